// File: rtl/mem_stage24.sv
// Memory stage of a 24-bit pipeline: ALU results go straight to writeback,
// loads/stores hold a request on the data-memory port until acknowledged or timed out.
module mem_stage24 #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_kind,
  input  logic [23:0] alu_y,
  input  logic [23:0] st_data,
  input  logic [2:0]  in_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [23:0] mem_addr,
  output logic [23:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [23:0] mem_rdata,
  output logic        wb_en,
  output logic [2:0]  wb_rd,
  output logic [23:0] wb_data,
  output logic        busy,
  output logic        err,
  input  logic        err_clr
);

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_WB} state_e;

  localparam logic [1:0] K_ALU   = 2'b00;
  localparam logic [1:0] K_LOAD  = 2'b01;
  localparam logic [1:0] K_STORE = 2'b10;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [1:0]  kind_q, kind_d;
  logic [23:0] addr_q, addr_d;
  logic [23:0] wdata_q, wdata_d;
  logic [2:0]  rd_q, rd_d;
  logic [23:0] wbdata_q, wbdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        timeout;

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    wbdata_d = wbdata_q;
    cnt_d    = cnt_q;
    timeout  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          kind_d  = in_kind;
          addr_d  = alu_y;
          wdata_d = st_data;
          rd_d    = in_rd;
          cnt_d   = 8'd0;
          case (in_kind)
            K_ALU: begin
              wbdata_d = alu_y;
              state_d  = S_WB;
            end
            K_LOAD, K_STORE: state_d = S_MEM;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_MEM: begin
        // An ack in the final allowed cycle still counts as a normal completion.
        if (mem_ack) begin
          if (kind_q == K_LOAD) begin
            wbdata_d = mem_rdata;
            state_d  = S_WB;
          end else begin
            state_d = S_IDLE;
          end
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    err_d = timeout ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      kind_q   <= 2'b00;
      addr_q   <= 24'd0;
      wdata_q  <= 24'd0;
      rd_q     <= 3'd0;
      wbdata_q <= 24'd0;
      cnt_q    <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      wbdata_q <= wbdata_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Strobes decode from registered state only, so in_valid never reaches mem_req.
  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign mem_req   = (state_q == S_MEM);
  assign mem_we    = (state_q == S_MEM) && (kind_q == K_STORE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign wb_en     = (state_q == S_WB) && (rd_q != 3'd0);
  assign wb_rd     = rd_q;
  assign wb_data   = wbdata_q;
  assign err       = err_q;

endmodule

// File: doc/mem_stage24.md
MEM_STAGE24 -- requirements
Module: mem_stage24

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the max MEM cycles to wait for mem_ack (range 1..255).
REQ-002 SHALL have port clk  input  1  single rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  execute stage presents an instruction result.
REQ-005 SHALL have port in_ready  output  1  stage can accept; transfer occurs when in_valid && in_ready at a clk edge.
REQ-006 SHALL have port in_kind  input  2  00 ALU writeback, 01 LOAD, 10 STORE, 11 no-writeback (branch/NOP).
REQ-007 SHALL have port alu_y  input  24  ALU result; writeback data for kind 00, memory address for 01/10.
REQ-008 SHALL have port st_data  input  24  store data for kind 10.
REQ-009 SHALL have port in_rd  input  3  destination register index.
REQ-010 SHALL have port mem_req  output  1  data-memory request, held until acknowledged.
REQ-011 SHALL have port mem_we  output  1  1 = write, 0 = read.
REQ-012 SHALL have port mem_addr  output  24  memory address.
REQ-013 SHALL have port mem_wdata  output  24  store data.
REQ-014 SHALL have port mem_ack  input  1  memory completes the request in this cycle.
REQ-015 SHALL have port mem_rdata  input  24  read data, valid when mem_ack=1 on a read.
REQ-016 SHALL have port wb_en  output  1  one-cycle register-file write strobe.
REQ-017 SHALL have port wb_rd  output  3  writeback register index.
REQ-018 SHALL have port wb_data  output  24  writeback value.
REQ-019 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-020 SHALL have port err  output  1  sticky memory-timeout flag.
REQ-021 SHALL have port err_clr  input  1  synchronous clear of err.

Function
REQ-022 SHALL implement FSM states IDLE, MEM, WB; in_ready = (state==IDLE).
REQ-023 SHALL, in IDLE on accept, latch alu_y, st_data, in_rd and in_kind; kind 00 -> WB; kind 01/10 -> MEM; kind 11 -> stay IDLE with no output effect.
REQ-024 SHALL, in MEM, drive mem_req=1 with mem_addr = latched alu_y, mem_we = (kind==10), mem_wdata = latched st_data, all stable until the cycle mem_ack is sampled high.
REQ-025 SHALL, on mem_ack in MEM: LOAD -> capture mem_rdata into wb_data, go to WB; STORE -> go to IDLE without writeback.
REQ-026 SHALL drive wb_en=1 for exactly the one WB cycle, with wb_rd and wb_data valid, then return to IDLE.
REQ-027 SHALL suppress wb_en when latched rd==0 (R0 is read-only); the FSM still passes through WB.
REQ-028 SHALL meet these latencies: ALU op accepted at edge N -> wb_en high in cycle N+1; LOAD accepted at N with ack in first MEM cycle -> mem_req high in cycle N+1, wb_en high in cycle N+2.
REQ-029 SHALL count MEM cycles with an 8-bit counter cleared on MEM entry; if TIMEOUT cycles elapse with no ack, set err, drop mem_req, return to IDLE, no writeback.
REQ-030 SHALL treat mem_ack arriving in the same cycle as the timeout as a normal completion, with no err.
REQ-031 SHALL ignore mem_ack and mem_rdata outside MEM.
REQ-032 SHALL, when err_clr and a timeout coincide, leave err=1 (set wins).
REQ-033 SHALL hold mem_req, mem_we and wb_en at 0 outside their states, with no combinational path from in_valid to mem_req.

Reset
REQ-034 SHALL, while rst_n=0, asynchronously force state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, wb_en=0, wb_rd=0, wb_data=0, counter=0 and err=0; in_ready=1 and busy=0.
REQ-035 SHALL, on reset mid-MEM or mid-WB, abandon the operation with no writeback after release; the first accept SHALL be possible in the first cycle after rst_n rises.

Verification
REQ-036 SHALL cover: ALU kind 00, alu_y=0x00ABCD, rd=3 -> next cycle wb_en=1, wb_rd=3, wb_data=0x00ABCD, busy=1 for one cycle only.
REQ-037 SHALL cover: LOAD addr=0x000010, ack after 3 cycles with rdata=0x123456, rd=5 -> mem_req high 3 cycles, mem_we=0, then wb_en with 0x123456 to rd 5.
REQ-038 SHALL cover: STORE addr=0x000020, data=0xFFFFFF, ack on cycle 1 -> mem_we=1, mem_wdata=0xFFFFFF, no wb_en, in_ready=1 the following cycle.
REQ-039 SHALL cover: LOAD with no ack, TIMEOUT=4 -> mem_req drops after 4 cycles, err=1 and stays 1, no wb_en; err_clr pulse -> err=0.
REQ-040 SHALL cover: ALU op with rd=0 -> no wb_en; also rst_n low during MEM -> mem_req=0 immediately, and no wb_en after release.
REQ-041 SHALL cover: back-to-back in_valid held high -> one accept per completed operation, in_ready=0 throughout MEM/WB.
